// File: rtl/score_pkg.sv
// Shared definitions for the two-player BCD score arbiter: FSM state
// encoding, player index constants and the default winning score.
package score_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UNITS = 3'd1,
    ST_TENS  = 3'd2,
    ST_DONE  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Player indices double as array indices and as the Winner encoding.
  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  // Two-digit BCD winning score (15 points).
  localparam logic [7:0] DEFAULT_WIN_SCORE = 8'h15;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: increments on request and wraps 9 -> 0 with a
// carry out, so the stored value can never exceed 9.
module bcd_digit (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] value,
  output logic       carry
);

  assign carry = inc && (value == 4'd9);

  // Digit register: clear dominates increment; increment wraps at 9.
  // NOTE: the reset branch and the synchronous clear both zero the digit; the
  // async reset covers power-up, the clear covers a new game mid-run.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      value <= 4'd0;
    end else if (clear) begin
      value <= 4'd0;
    end else if (inc) begin
      value <= carry ? 4'd0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/score_arbiter.sv
// Two-player score arbiter. A single FSM walks one point at a time through a
// shared units/tens increment sequence and acknowledges the granted player.
// Optional win limit: define SCORE_WIN_LIMIT_EN to stop the game once the
// granted player's score equals WIN_SCORE; otherwise scores wrap 99 -> 00.
module score_arbiter
  import score_pkg::*;
#(
  parameter logic [7:0] WIN_SCORE = DEFAULT_WIN_SCORE
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Clear,
  input  logic       Req_P1,
  input  logic       Req_P2,
  output logic       Ack_P1,
  output logic       Ack_P2,
  output logic [7:0] Score_P1,
  output logic [7:0] Score_P2,
  output logic       Busy,
  output logic       Game_Over,
  output logic       Winner
);

`ifdef SCORE_WIN_LIMIT_EN
  localparam logic WIN_LIMIT_EN = 1'b1;
`else
  localparam logic WIN_LIMIT_EN = 1'b0;
`endif

  state_t     state;
  state_t     state_next;
  logic       grant;        // player currently being served
  logic       last_served;  // round-robin pointer for simultaneous requests
  logic       pick;
  logic [1:0] units_inc;
  logic [1:0] tens_inc;
  logic [1:0] units_carry;
  logic [1:0] tens_carry;
  logic [3:0] units_val [2];
  logic [3:0] tens_val  [2];
  logic [7:0] granted_score;
  logic       win_hit;

  // The tens carry is the 99 -> 00 wrap; nothing downstream needs it.
  logic       unused_tens_carry;
  assign unused_tens_carry = ^tens_carry;

  // One digit pair per player; the FSM steers a single increment to one digit.
  for (genvar p = 0; p < 2; p++) begin : g_player
    bcd_digit u_units (
      .Clock (Clock),
      .Reset (Reset),
      .clear (Clear),
      .inc   (units_inc[p]),
      .value (units_val[p]),
      .carry (units_carry[p])
    );
    bcd_digit u_tens (
      .Clock (Clock),
      .Reset (Reset),
      .clear (Clear),
      .inc   (tens_inc[p]),
      .value (tens_val[p]),
      .carry (tens_carry[p])
    );
  end

  assign Score_P1      = {tens_val[PLAYER_1], units_val[PLAYER_1]};
  assign Score_P2      = {tens_val[PLAYER_2], units_val[PLAYER_2]};
  assign granted_score = (grant == PLAYER_2) ? Score_P2 : Score_P1;
  assign win_hit       = WIN_LIMIT_EN && (granted_score == WIN_SCORE);

  // Arbitration: a lone requester wins; on a tie serve the other player.
  always_comb begin
    if (Req_P1 && Req_P2) begin
      pick = ~last_served;
    end else if (Req_P2) begin
      pick = PLAYER_2;
    end else begin
      pick = PLAYER_1;
    end
  end

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; Clear returns to IDLE from anywhere.
  always_comb begin
    state_next = state;
    if (Clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (Req_P1 || Req_P2) state_next = ST_UNITS;
        ST_UNITS: state_next = units_carry[grant] ? ST_TENS : ST_DONE;
        ST_TENS:  state_next = ST_DONE;
        ST_DONE:  state_next = win_hit ? ST_OVER : ST_IDLE;
        ST_OVER:  state_next = ST_OVER;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Grant latch in IDLE and round-robin pointer update on completion.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      grant       <= PLAYER_1;
      last_served <= PLAYER_2;
    end else if (Clear) begin
      grant       <= PLAYER_1;
      last_served <= PLAYER_2;
    end else begin
      if (state == ST_IDLE && (Req_P1 || Req_P2)) grant <= pick;
      if (state == ST_DONE) last_served <= grant;
    end
  end

  // Outputs and digit increment steering, all decoded from the current state.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    units_inc = 2'b00;
    tens_inc  = 2'b00;
    Ack_P1    = 1'b0;
    Ack_P2    = 1'b0;
    Busy      = (state != ST_IDLE);
    Game_Over = WIN_LIMIT_EN && (state == ST_OVER);
    Winner    = Game_Over ? grant : 1'b0;
    if (!Clear) begin
      case (state)
        ST_UNITS: units_inc[grant] = 1'b1;
        ST_TENS:  tens_inc[grant]  = 1'b1;
        ST_DONE: begin
          Ack_P1 = (grant == PLAYER_1);
          Ack_P2 = (grant == PLAYER_2);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_arbiter.sv
// Scoreboard bench for score_arbiter: the driver pushes expected acks
// (player, both scores, cycle of arrival) computed from decimal point counts;
// an independent monitor pops and compares on every observed Ack.
module tb_score_arbiter;

  logic       Clock   = 1'b0;
  logic       Reset   = 1'b1;
  logic       Clear   = 1'b0;
  logic       Req_P1  = 1'b0;
  logic       Req_P2  = 1'b0;
  logic       Ack_P1;
  logic       Ack_P2;
  logic [7:0] Score_P1;
  logic [7:0] Score_P2;
  logic       Busy;
  logic       Game_Over;
  logic       Winner;

  typedef struct {
    bit         player;   // 0 = P1, 1 = P2
    logic [7:0] s1;
    logic [7:0] s2;
    int         ack_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_score[2] = '{0, 0};
  bit   m_last     = 1'b1;   // last served; P2 so that P1 is favoured

  score_arbiter dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Clear     (Clear),
    .Req_P1    (Req_P1),
    .Req_P2    (Req_P2),
    .Ack_P1    (Ack_P1),
    .Ack_P2    (Ack_P2),
    .Score_P1  (Score_P1),
    .Score_P2  (Score_P2),
    .Busy      (Busy),
    .Game_Over (Game_Over),
    .Winner    (Winner)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // Model one committed point for player p whose grant edge follows cycle
  // 'start'; a units digit of 9 costs one extra cycle for the tens step.
  task automatic push_point(input bit p, input int start, output int ack_at);
    int s;
    int lat;
    exp_t e;
    s         = m_score[p];
    lat       = (s % 10 == 9) ? 3 : 2;
    m_score[p] = (s + 1) % 100;
    m_last    = p;
    ack_at    = start + lat;
    e.player  = p;
    e.s1      = to_bcd(m_score[0]);
    e.s2      = to_bcd(m_score[1]);
    e.ack_cyc = ack_at;
    sb.push_back(e);
  endtask

  // Raise the requested Req lines from IDLE, hold each until its Ack.
  task automatic do_point(input bit w1, input bit w2);
    bit first;
    bit pend1;
    bit pend2;
    bit a1;
    bit a2;
    int c0;
    int ack_at;
    int guard;
    @(posedge Clock); #1;
    c0    = cyc;
    first = (w1 && w2) ? ~m_last : w2;
    push_point(first, c0, ack_at);
    if (w1 && w2) push_point(~first, ack_at + 1, ack_at);
    Req_P1 = w1;
    Req_P2 = w2;
    pend1  = w1;
    pend2  = w2;
    guard  = 0;
    while ((pend1 || pend2) && guard < 40) begin
      @(negedge Clock);
      a1 = Ack_P1;
      a2 = Ack_P2;
      @(posedge Clock); #1;
      if (a1 && pend1) begin Req_P1 = 1'b0; pend1 = 1'b0; end
      if (a2 && pend2) begin Req_P2 = 1'b0; pend2 = 1'b0; end
      guard++;
    end
    check("ack_arrived", 32'({pend1, pend2}), 32'd0);
    Req_P1 = 1'b0;
    Req_P2 = 1'b0;
  endtask

  task automatic do_clear();
    @(posedge Clock); #1;
    Clear = 1'b1;
    @(posedge Clock); #1;
    Clear = 1'b0;
    m_score = '{0, 0};
    m_last  = 1'b1;
    check("clear_p1", 32'(Score_P1), 32'h00);
    check("clear_p2", 32'(Score_P2), 32'h00);
  endtask

  // Monitor: every Ack must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (!Reset && (Ack_P1 || Ack_P2)) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'({Ack_P1, Ack_P2}), 32'd0);
        end else begin
          e = sb.pop_front();
          check("ack_player", 32'({Ack_P1, Ack_P2}), e.player ? 32'd1 : 32'd2);
          check("ack_score_p1", 32'(Score_P1), 32'(e.s1));
          check("ack_score_p2", 32'(Score_P2), 32'(e.s2));
          check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          check("busy_at_ack", 32'(Busy), 32'd1);
          check("game_over_at_ack", 32'(Game_Over), 32'd0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state.
    #2;
    check("rst_score_p1", 32'(Score_P1), 32'h00);
    check("rst_score_p2", 32'(Score_P2), 32'h00);
    check("rst_ack", 32'({Ack_P1, Ack_P2}), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_game_over", 32'(Game_Over), 32'd0);
    check("rst_winner", 32'(Winner), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock); #1;

    // Single point, then units carry into tens.
    do_point(1'b1, 1'b0);
    check("first_point_p1", 32'(Score_P1), 32'h01);
    repeat (8) do_point(1'b1, 1'b0);
    do_point(1'b1, 1'b0);
    check("carry_p1", 32'(Score_P1), 32'h10);

    // Reset in the middle of an operation discards it.
    @(posedge Clock); #1;
    Req_P1 = 1'b1;
    @(posedge Clock); #1;
    check("busy_in_units", 32'(Busy), 32'd1);
    Reset = 1'b1;
    #1;
    check("midrst_score_p1", 32'(Score_P1), 32'h00);
    check("midrst_busy", 32'(Busy), 32'd0);
    Req_P1 = 1'b0;
    @(posedge Clock); #1;
    Reset   = 1'b0;
    m_score = '{0, 0};
    m_last  = 1'b1;
    repeat (6) @(posedge Clock);
    #1;

    // Simultaneous requests: P1 first, then P2.
    do_point(1'b1, 1'b1);
    check("tie_p1", 32'(Score_P1), 32'h01);
    check("tie_p2", 32'(Score_P2), 32'h01);

    // Randomised mix of single and simultaneous requests.
    for (int i = 0; i < 24; i++) begin
      int mode;
`ifdef SCORE_WIN_LIMIT_EN
      if (m_score[0] >= 12 || m_score[1] >= 12) do_clear();
`endif
      if ($urandom_range(0, 7) == 0) do_clear();
      repeat ($urandom_range(0, 3)) begin @(posedge Clock); #1; end
      mode = $urandom_range(0, 2);
      do_point(mode != 1, mode != 0);
    end

    // Clear during TENS aborts the point with no Ack.
    do_clear();
    repeat (9) do_point(1'b1, 1'b0);
    do_point(1'b0, 1'b1);
    @(posedge Clock); #1;
    Req_P1 = 1'b1;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    check("busy_in_tens", 32'(Busy), 32'd1);
    check("tens_units_wrapped", 32'(Score_P1), 32'h00);
    Clear = 1'b1;
    @(negedge Clock);
    check("no_ack_on_clear", 32'({Ack_P1, Ack_P2}), 32'd0);
    @(posedge Clock); #1;
    Clear  = 1'b0;
    Req_P1 = 1'b0;
    m_score = '{0, 0};
    m_last  = 1'b1;
    check("abort_p1", 32'(Score_P1), 32'h00);
    check("abort_p2", 32'(Score_P2), 32'h00);
    check("abort_idle", 32'(Busy), 32'd0);
    repeat (4) @(posedge Clock);
    #1;

`ifdef SCORE_WIN_LIMIT_EN
    // Reaching the winning score ends the game and freezes everything.
    do_clear();
    repeat (14) do_point(1'b0, 1'b1);
    do_point(1'b0, 1'b1);
    check("win_score_p2", 32'(Score_P2), 32'h15);
    check("win_game_over", 32'(Game_Over), 32'd1);
    check("win_winner", 32'(Winner), 32'd1);
    Req_P1 = 1'b1;
    repeat (10) @(posedge Clock);
    #1;
    Req_P1 = 1'b0;
    check("over_frozen_p1", 32'(Score_P1), 32'h00);
    check("over_frozen_p2", 32'(Score_P2), 32'h15);
    check("over_busy", 32'(Busy), 32'd1);
    do_clear();
    check("over_cleared", 32'(Game_Over), 32'd0);
`else
    // Without the win limit a score wraps 99 -> 00.
    do_clear();
    repeat (99) do_point(1'b1, 1'b0);
    check("p1_at_99", 32'(Score_P1), 32'h99);
    do_point(1'b1, 1'b0);
    check("wrap_p1", 32'(Score_P1), 32'h00);
    check("wrap_game_over", 32'(Game_Over), 32'd0);
    check("wrap_winner", 32'(Winner), 32'd0);
`endif

    repeat (5) @(posedge Clock);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
